// File: rtl/cnn_pkg.sv
// Types, default widths and arithmetic helpers shared by the CNN datapath stages
// (conv, pool and the fully-connected classifier).
package cnn_pkg;

    localparam int CNN_IN_W  = 16;
    localparam int CNN_W_W   = 8;
    localparam int CNN_ACC_W = 32;
    localparam int CNN_OUT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_BIAS,
        ST_BIAS_ADD,
        ST_SCALE,
        ST_ARGMAX,
        ST_DONE
    } fc_state_e;

    // Clamp a sign-extended accumulator value into the signed range of out_w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int                 out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One class lane of the FC layer: accumulates feature*weight products, folds in
// the pre-shifted bias, then scales and saturates the result into a score.
module fc_mac_lane
    import cnn_pkg::*;
#(
    parameter int IN_W       = CNN_IN_W,
    parameter int W_W        = CNN_W_W,
    parameter int ACC_W      = CNN_ACC_W,
    parameter int OUT_W      = CNN_OUT_W,
    parameter int FRAC_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    mac_en,
    input  logic                    bias_en,
    input  logic                    scale_en,
    input  logic signed [IN_W-1:0]  feat,
    input  logic signed [W_W-1:0]   wt,
    output logic signed [OUT_W-1:0] score
);

    localparam int P_W = IN_W + W_W;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] score_q, score_d;
    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [63:0]      shifted;

    always_comb begin
        prod     = P_W'(feat) * P_W'(wt);
        prod_ext = ACC_W'(prod);
        // Bias is stored in output units, so it is lifted to accumulator scale.
        bias_ext = ACC_W'(wt) <<< FRAC_SHIFT;
        shifted  = 64'(acc_q) >>> FRAC_SHIFT;

        acc_d   = acc_q;
        score_d = score_q;
        if (clr) begin
            acc_d = '0;
        end else if (mac_en) begin
            acc_d = acc_q + prod_ext;
        end else if (bias_en) begin
            acc_d = acc_q + bias_ext;
        end
        if (scale_en) begin
            score_d = OUT_W'(saturate(shifted, OUT_W));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            score_q <= '0;
        end else begin
            acc_q   <= acc_d;
            score_q <= score_d;
        end
    end

    assign score = score_q;

endmodule

// File: rtl/fc_classifier.sv
// Fully-connected output layer with integrated arg-max: streams a feature vector,
// runs one MAC lane per class against an external weight ROM, then picks the winner.
module fc_classifier
    import cnn_pkg::*;
#(
    parameter int IN_W        = CNN_IN_W,
    parameter int W_W         = CNN_W_W,
    parameter int ACC_W       = CNN_ACC_W,
    parameter int OUT_W       = CNN_OUT_W,
    parameter int NUM_IN      = 64,
    parameter int NUM_CLASSES = 10,
    parameter int FRAC_SHIFT  = 8,
    parameter int ADDR_W      = $clog2(NUM_IN + 1),
    parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         feat_valid,
    input  logic signed [IN_W-1:0]       feat_data,
    output logic                         feat_ready,
    output logic [ADDR_W-1:0]            wt_addr,
    input  logic [NUM_CLASSES*W_W-1:0]   wt_data,
    input  logic [3:0]                   sel_class,
    output logic signed [OUT_W-1:0]      sel_score,
    output logic                         busy,
    output logic                         done,
    output logic [CLS_W-1:0]             class_idx,
    output logic                         result_valid
);

    fc_state_e state_q, state_d;

    logic [ADDR_W-1:0]       count_q, count_d;
    logic                    mac_pending_q, mac_pending_d;
    logic signed [IN_W-1:0]  feat_q, feat_d;
    logic [CLS_W-1:0]        arg_k_q, arg_k_d;
    logic [CLS_W-1:0]        best_idx_q, best_idx_d;
    logic signed [OUT_W-1:0] best_val_q, best_val_d;
    logic [CLS_W-1:0]        class_idx_q, class_idx_d;
    logic                    result_valid_q, result_valid_d;

    logic                    hs;
    logic                    start_acc;
    logic                    last_feat;
    logic                    last_class;
    logic                    bias_en;
    logic                    scale_en;
    logic signed [OUT_W-1:0] score [NUM_CLASSES];
    logic signed [OUT_W-1:0] cand;

    assign hs         = feat_valid && feat_ready;
    assign start_acc  = (state_q == ST_IDLE) && start;
    assign last_feat  = (count_q == ADDR_W'(NUM_IN - 1));
    assign last_class = (arg_k_q == CLS_W'(NUM_CLASSES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (start) state_d = ST_ACCUM;
            ST_ACCUM:    if (hs && last_feat) state_d = ST_BIAS;
            ST_BIAS:     state_d = ST_BIAS_ADD;
            ST_BIAS_ADD: state_d = ST_SCALE;
            ST_SCALE:    state_d = ST_ARGMAX;
            ST_ARGMAX:   if (last_class) state_d = ST_DONE;
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        feat_ready = 1'b0;
        busy       = 1'b1;
        wt_addr    = '0;
        bias_en    = 1'b0;
        scale_en   = 1'b0;
        done       = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE:     busy = 1'b0;
            ST_ACCUM: begin
                feat_ready = 1'b1;
                wt_addr    = count_q;
            end
            ST_BIAS:     wt_addr = ADDR_W'(NUM_IN);
            ST_BIAS_ADD: bias_en = 1'b1;
            ST_SCALE:    scale_en = 1'b1;
            default: ;
        endcase
    end

    // The MAC for a feature runs the cycle after its handshake, when the ROM row arrives.
    always_comb begin
        count_d        = count_q;
        mac_pending_d  = hs;
        feat_d         = hs ? feat_data : feat_q;
        arg_k_d        = (state_q == ST_ARGMAX) ? arg_k_q + CLS_W'(1) : '0;
        best_idx_d     = best_idx_q;
        best_val_d     = best_val_q;
        class_idx_d    = class_idx_q;
        result_valid_d = result_valid_q;
        cand           = score[arg_k_q];

        if (start_acc) begin
            count_d        = '0;
            result_valid_d = 1'b0;
        end else if (hs) begin
            count_d = count_q + ADDR_W'(1);
        end

        if (state_q == ST_ARGMAX) begin
            // Strictly-greater update keeps the lowest index on ties.
            if ((arg_k_q == '0) || (cand > best_val_q)) begin
                best_val_d = cand;
                best_idx_d = arg_k_q;
            end
            if (last_class) begin
                class_idx_d    = best_idx_d;
                result_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q        <= '0;
            mac_pending_q  <= 1'b0;
            feat_q         <= '0;
            arg_k_q        <= '0;
            best_idx_q     <= '0;
            best_val_q     <= '0;
            class_idx_q    <= '0;
            result_valid_q <= 1'b0;
        end else begin
            count_q        <= count_d;
            mac_pending_q  <= mac_pending_d;
            feat_q         <= feat_d;
            arg_k_q        <= arg_k_d;
            best_idx_q     <= best_idx_d;
            best_val_q     <= best_val_d;
            class_idx_q    <= class_idx_d;
            result_valid_q <= result_valid_d;
        end
    end

    for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_lane
        fc_mac_lane #(
            .IN_W      (IN_W),
            .W_W       (W_W),
            .ACC_W     (ACC_W),
            .OUT_W     (OUT_W),
            .FRAC_SHIFT(FRAC_SHIFT)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clr     (start_acc),
            .mac_en  (mac_pending_q),
            .bias_en (bias_en),
            .scale_en(scale_en),
            .feat    (feat_q),
            .wt      (wt_data[k*W_W +: W_W]),
            .score   (score[k])
        );
    end

    always_comb begin
        sel_score = '0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (int'(sel_class) == k) begin
                sel_score = score[k];
            end
        end
    end

    assign class_idx    = class_idx_q;
    assign result_valid = result_valid_q;

endmodule

// File: doc/fc_classifier.md
Name: fc_classifier

Overview:
- Parametrised fully-connected output layer with an integrated arg-max.
- Consumes a streamed flattened feature vector (pooled conv outputs) over a valid/ready handshake.
- Multiplies each feature against one weight row per class read from an external synchronous weight ROM, adds a per-class bias row, then scales and saturates each score.
- Reports the winning class index, plus any per-class score through a live select port. It replaces the fixed 10-output FC-plus-mux stage.

Parameters:
- IN_W, 16, signed feature width
- W_W, 8, signed weight/bias width
- ACC_W, 32, signed accumulator width
- OUT_W, 16, signed saturated score width
- NUM_IN, 64, features per frame (>=2)
- NUM_CLASSES, 10, output classes (>=2)
- FRAC_SHIFT, 8, arithmetic right shift applied to accumulator before saturation
- ADDR_W, $clog2(NUM_IN+1), weight ROM address width
- CLS_W, $clog2(NUM_CLASSES), class index width

Ports:
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-high
- start, in, 1, begin frame (one-cycle pulse)
- feat_valid, in, 1, feature present
- feat_data, in, IN_W, signed feature
- feat_ready, out, 1, block accepts feature
- wt_addr, out, ADDR_W, ROM row address (rows 0..NUM_IN-1 weights, row NUM_IN bias)
- wt_data, in, NUM_CLASSES*W_W, ROM row, class k at bits [k*W_W +: W_W]; valid one cycle after address
- sel_class, in, 4 (>=CLS_W), score select
- sel_score, out, OUT_W, combinational score[sel_class]; 0 if sel_class>=NUM_CLASSES
- busy, out, 1, frame in progress
- done, out, 1, one-cycle pulse, result ready
- class_idx, out, CLS_W, arg-max class
- result_valid, out, 1, class_idx/scores valid

Behaviour:
- Reset values: feat_ready=0, busy=0, done=0, result_valid=0, class_idx=0, wt_addr=0, all accumulators, scores and counters=0.
- FSM states: IDLE, ACCUM, BIAS, BIAS_ADD, SCALE, ARGMAX, DONE.
- IDLE:
  - feat_ready=0.
  - start -> clear accumulators, count, result_valid; go ACCUM.
  - feat_valid is ignored.
- ACCUM:
  - feat_ready=1; wt_addr=count.
  - Handshake (valid&ready) registers feat_data and raises mac_pending; count++.
  - Next cycle, each acc[k] += feat_q * wt_data[k], sign-extended to ACC_W; the ACC_W wrap is not detected.
  - Gaps in feat_valid stall the count only; mac_pending drains independently.
  - Handshake with count==NUM_IN-1 -> BIAS.
- BIAS:
  - feat_ready=0; wt_addr=NUM_IN.
  - The last pending MAC completes this cycle.
- BIAS_ADD: acc[k] += bias[k] <<< FRAC_SHIFT.
- SCALE: score[k] = saturate(acc[k] >>> FRAC_SHIFT) to [-2^(OUT_W-1), 2^(OUT_W-1)-1], all classes in parallel.
- ARGMAX:
  - Sweeps k=0..NUM_CLASSES-1, one class per cycle.
  - Replaces best only on strictly greater, so ties resolve to the lowest index.
- DONE:
  - done=1 for one cycle; class_idx and result_valid=1 registered; go IDLE.
- Latency: done is high exactly NUM_CLASSES+4 cycles after the last-feature handshake cycle.
- busy=1 in every state except IDLE.
- start while busy is ignored; no restart.
- Results hold until the next accepted start, which clears result_valid the following cycle.
- rst at any time aborts the frame immediately and returns all outputs to their reset values. The next frame needs a fresh start.
- sel_score is valid only while result_valid=1; otherwise it shows the intermediate score registers.

Decomposition:
- Shared package cnn_pkg:
  - FSM state enum
  - saturate function (ACC_W -> OUT_W)
  - default width constants shared with the conv/pool stages
- One sub-module, fc_mac_lane: a single class accumulator with MAC, bias add and saturating scale; instantiated NUM_CLASSES times by generate.
- The FSM, handshake, ROM addressing and arg-max live in the parent.

Test Plan (bench config NUM_IN=4, NUM_CLASSES=3, FRAC_SHIFT=0 unless stated):
- Basic: class-2 weights all 1, others 0, bias 0, features 1,2,3,4 streamed back-to-back -> scores {0,0,10}, class_idx=2, done 7 cycles after 4th handshake.
- Bias/shift: FRAC_SHIFT=2, weights 4, bias {1,0,0}, features 1,1,1,1 -> acc {20,16,16}, scores {5,4,4}, class_idx=0.
- Saturation: features 32767, weights 127 (class0) / -128 (class1) -> score0=32767, score1=-32768, class_idx=0.
- Tie and backpressure: identical rows, feat_valid toggled 1-0-0-1-1-0-1 -> class_idx=0; feat_ready low outside ACCUM; done timed from last handshake.
- Reset mid-frame: rst after 2 handshakes -> all outputs 0; a subsequent full frame of the basic case gives {0,0,10} with no residue.
- Misc: sel_class=3 -> sel_score=0; start pulsed during ARGMAX -> ignored, single done pulse.
